// File: rtl/gabor_sort_pkg.sv
// Shared types, default widths and the ranking comparator for the Gabor coefficient sorter.
// Build option: SORT_SIGNED_EN ranks by the signed value of {sign,mag} instead of magnitude only.
package gabor_sort_pkg;

   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_MAG_W       = 10;
   localparam int DEF_KERNEL_SIZE = 5;
   localparam int DEF_IDX_W       = $clog2(DEF_NUM_CH);
   localparam int KEY_W           = 32;

`ifdef SORT_SIGNED_EN
   localparam logic SIGNED_KEY = 1'b1;
`else
   localparam logic SIGNED_KEY = 1'b0;
`endif

   typedef struct packed {
      logic                 sign;
      logic [DEF_MAG_W-1:0] mag;
   } coeff_t;

   typedef struct packed {
      coeff_t               coeff;
      logic [DEF_IDX_W-1:0] idx;
   } lane_t;

   // A tap counts as negative only in the signed build and only when non-zero (-0 == +0).
   function automatic logic key_neg(input logic sign, input logic [KEY_W-1:0] mag);
      return SIGNED_KEY & sign & (mag != {KEY_W{1'b0}});
   endfunction

   // True when lane a must stay above lane b; equal keys keep ascending channel order.
   function automatic logic key_gt(input logic neg_a, input logic [KEY_W-1:0] mag_a,
                                   input logic [KEY_W-1:0] idx_a,
                                   input logic neg_b, input logic [KEY_W-1:0] mag_b,
                                   input logic [KEY_W-1:0] idx_b);
      logic gt;
      if (neg_a != neg_b) begin
         gt = neg_b;
      end else if (mag_a == mag_b) begin
         gt = (idx_a < idx_b);
      end else if (neg_a) begin
         gt = (mag_a < mag_b);
      end else begin
         gt = (mag_a > mag_b);
      end
      return gt;
   endfunction

endpackage

// File: rtl/sort_cas_cell.sv
// Combinational compare-and-swap of two ranked lanes; the winner leaves on the hi port.
module sort_cas_cell
   import gabor_sort_pkg::*;
#(
   parameter int MAG_W = DEF_MAG_W,
   parameter int IDX_W = DEF_IDX_W
)(
   input  logic [MAG_W:0]   a_coeff,
   input  logic [IDX_W-1:0] a_idx,
   input  logic [MAG_W:0]   b_coeff,
   input  logic [IDX_W-1:0] b_idx,
   output logic [MAG_W:0]   hi_coeff,
   output logic [IDX_W-1:0] hi_idx,
   output logic [MAG_W:0]   lo_coeff,
   output logic [IDX_W-1:0] lo_idx
);

   logic keep_s;

   // Keep order when a outranks b, otherwise swap the whole lane.
   always_comb begin
      keep_s = key_gt(key_neg(a_coeff[MAG_W], KEY_W'(a_coeff[MAG_W-1:0])),
                      KEY_W'(a_coeff[MAG_W-1:0]), KEY_W'(a_idx),
                      key_neg(b_coeff[MAG_W], KEY_W'(b_coeff[MAG_W-1:0])),
                      KEY_W'(b_coeff[MAG_W-1:0]), KEY_W'(b_idx));
      if (keep_s) begin
         hi_coeff = a_coeff;
         hi_idx   = a_idx;
         lo_coeff = b_coeff;
         lo_idx   = b_idx;
      end else begin
         hi_coeff = b_coeff;
         hi_idx   = b_idx;
         lo_coeff = a_coeff;
         lo_idx   = a_idx;
      end
   end

endmodule

// File: rtl/coeff_rank_sorter.sv
// Streaming argsort of NUM_CH kernel taps per beat through NUM_CH odd-even transposition stages.
// Build option: SORT_SIGNED_EN (see gabor_sort_pkg) selects signed ranking.
module coeff_rank_sorter
   import gabor_sort_pkg::*;
#(
   parameter int  NUM_CH      = DEF_NUM_CH,
   parameter int  MAG_W       = DEF_MAG_W,
   parameter int  KERNEL_SIZE = DEF_KERNEL_SIZE,
   localparam int CW          = MAG_W + 1,
   localparam int IDX_W       = $clog2(NUM_CH),
   localparam int POS_W       = $clog2(KERNEL_SIZE)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_CH*CW-1:0]    in_coeff,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NUM_CH*CW-1:0]    out_coeff,
   output logic [NUM_CH*IDX_W-1:0] out_idx,
   output logic [POS_W-1:0]        out_row,
   output logic [POS_W-1:0]        out_col,
   output logic                    out_last
);

   localparam logic [POS_W-1:0] POS_MAX = POS_W'(KERNEL_SIZE - 1);

   logic [NUM_CH*CW-1:0]    stg_coeff_s [NUM_CH];
   logic [NUM_CH*IDX_W-1:0] stg_idx_s   [NUM_CH];
   logic [NUM_CH*CW-1:0]    srt_coeff_s [NUM_CH];
   logic [NUM_CH*IDX_W-1:0] srt_idx_s   [NUM_CH];
   logic [NUM_CH*CW-1:0]    coeff_r     [NUM_CH];
   logic [NUM_CH*IDX_W-1:0] idx_r       [NUM_CH];
   logic [POS_W-1:0]        row_r       [NUM_CH];
   logic [POS_W-1:0]        col_r       [NUM_CH];
   logic [NUM_CH-1:0]       valid_r;
   logic [NUM_CH-1:0]       last_r;
   logic [POS_W-1:0]        row_cnt_r;
   logic [POS_W-1:0]        col_cnt_r;
   logic                    en_s;
   logic                    acc_s;
   logic                    tag_last_s;

   assign en_s       = out_ready | ~valid_r[NUM_CH-1];
   assign acc_s      = in_valid & en_s;
   assign tag_last_s = (row_cnt_r == POS_MAX) && (col_cnt_r == POS_MAX);

   for (genvar s = 0; s < NUM_CH; s++) begin : g_stage
      if (s == 0) begin : g_head
         assign stg_coeff_s[0] = in_coeff;
         for (genvar c = 0; c < NUM_CH; c++) begin : g_idx
            assign stg_idx_s[0][c*IDX_W +: IDX_W] = IDX_W'(c);
         end
      end else begin : g_body
         assign stg_coeff_s[s] = coeff_r[s-1];
         assign stg_idx_s[s]   = idx_r[s-1];
      end
      // Even stages pair (2k,2k+1), odd stages pair (2k+1,2k+2); edge lanes without a partner pass.
      for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
         if (((c % 2) == (s % 2)) && ((c + 1) < NUM_CH)) begin : g_cas
            sort_cas_cell #(.MAG_W(MAG_W), .IDX_W(IDX_W)) u_cas (
               .a_coeff  (stg_coeff_s[s][c*CW +: CW]),
               .a_idx    (stg_idx_s[s][c*IDX_W +: IDX_W]),
               .b_coeff  (stg_coeff_s[s][(c+1)*CW +: CW]),
               .b_idx    (stg_idx_s[s][(c+1)*IDX_W +: IDX_W]),
               .hi_coeff (srt_coeff_s[s][c*CW +: CW]),
               .hi_idx   (srt_idx_s[s][c*IDX_W +: IDX_W]),
               .lo_coeff (srt_coeff_s[s][(c+1)*CW +: CW]),
               .lo_idx   (srt_idx_s[s][(c+1)*IDX_W +: IDX_W])
            );
         end else if (!((c >= 1) && (((c - 1) % 2) == (s % 2)))) begin : g_pass
            assign srt_coeff_s[s][c*CW +: CW]       = stg_coeff_s[s][c*CW +: CW];
            assign srt_idx_s[s][c*IDX_W +: IDX_W]   = stg_idx_s[s][c*IDX_W +: IDX_W];
         end
      end
   end

   // Stage registers: all stages shift together whenever the output side can move.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= {NUM_CH{1'b0}};
         last_r  <= {NUM_CH{1'b0}};
         for (int i = 0; i < NUM_CH; i++) begin
            coeff_r[i] <= {(NUM_CH*CW){1'b0}};
            idx_r[i]   <= {(NUM_CH*IDX_W){1'b0}};
            row_r[i]   <= {POS_W{1'b0}};
            col_r[i]   <= {POS_W{1'b0}};
         end
      end else if (en_s) begin
         valid_r[0] <= in_valid;
         last_r[0]  <= in_valid & tag_last_s;
         row_r[0]   <= row_cnt_r;
         col_r[0]   <= col_cnt_r;
         coeff_r[0] <= srt_coeff_s[0];
         idx_r[0]   <= srt_idx_s[0];
         for (int i = 1; i < NUM_CH; i++) begin
            valid_r[i] <= valid_r[i-1];
            last_r[i]  <= last_r[i-1];
            row_r[i]   <= row_r[i-1];
            col_r[i]   <= col_r[i-1];
            coeff_r[i] <= srt_coeff_s[i];
            idx_r[i]   <= srt_idx_s[i];
         end
      end
   end

   // Window position of the next accepted tap; bubbles leave it untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt_r <= {POS_W{1'b0}};
         col_cnt_r <= {POS_W{1'b0}};
      end else if (acc_s) begin
         if (col_cnt_r == POS_MAX) begin
            col_cnt_r <= {POS_W{1'b0}};
            row_cnt_r <= (row_cnt_r == POS_MAX) ? {POS_W{1'b0}} : row_cnt_r + POS_W'(1);
         end else begin
            col_cnt_r <= col_cnt_r + POS_W'(1);
         end
      end
   end

   assign in_ready  = en_s;
   assign out_valid = valid_r[NUM_CH-1];
   assign out_last  = last_r[NUM_CH-1];
   assign out_coeff = coeff_r[NUM_CH-1];
   assign out_idx   = idx_r[NUM_CH-1];
   assign out_row   = row_r[NUM_CH-1];
   assign out_col   = col_r[NUM_CH-1];

endmodule

// File: tb/tb_coeff_rank_sorter.sv
// Self-checking bench for coeff_rank_sorter: directed steps plus a rank-counting scoreboard model.
module tb_coeff_rank_sorter;

   localparam int NC = 4;
   localparam int CW = 11;
   localparam int IW = 2;
   localparam int PW = 3;
   localparam int K  = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [43:0]   in_coeff;
   logic          out_valid;
   logic          out_ready;
   logic [43:0]   out_coeff;
   logic [7:0]    out_idx;
   logic [2:0]    out_row;
   logic [2:0]    out_col;
   logic          out_last;

   typedef struct packed {
      logic [43:0] coeff;
      logic [7:0]  idx;
      logic [2:0]  row;
      logic [2:0]  col;
      logic        last;
   } exp_t;

   exp_t        sb_q[$];
   int          n_pass = 0;
   int          n_total = 0;
   int          pos_m = 0;
   logic        stall_prev = 1'b0;
   logic [43:0] hold_coeff;
   logic [7:0]  hold_idx;
   logic [2:0]  hold_row;
   int          lat;

   coeff_rank_sorter dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_coeff(out_coeff), .out_idx(out_idx),
      .out_row(out_row), .out_col(out_col), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic int key_of(input logic [10:0] c);
`ifdef SORT_SIGNED_EN
      return c[10] ? -int'(c[9:0]) : int'(c[9:0]);
`else
      return int'(c[9:0]);
`endif
   endfunction

   // Rank of a tap = number of taps that must sit above it.
   function automatic exp_t model(input logic [43:0] v, input int p);
      exp_t e;
      int   r;
      int   ki;
      int   kj;
      e.coeff = 44'd0;
      e.idx   = 8'd0;
      for (int i = 0; i < NC; i++) begin
         r  = 0;
         ki = key_of(v[i*CW +: CW]);
         for (int j = 0; j < NC; j++) begin
            kj = key_of(v[j*CW +: CW]);
            if (j != i && (kj > ki || (kj == ki && j < i))) r++;
         end
         e.coeff[r*CW +: CW] = v[i*CW +: CW];
         e.idx[r*IW +: IW]   = IW'(i);
      end
      e.row  = PW'(p / K);
      e.col  = PW'(p % K);
      e.last = (p == K*K - 1);
      return e;
   endfunction

   function automatic logic [43:0] pack4(input logic [10:0] c0, input logic [10:0] c1,
                                         input logic [10:0] c2, input logic [10:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   function automatic logic [43:0] rnd_beat();
      logic [43:0] v;
      for (int c = 0; c < NC; c++) begin
         v[c*CW + 10] = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) v[c*CW +: 10] = 10'($urandom_range(0, 3));
         else                           v[c*CW +: 10] = 10'($urandom_range(0, 1023));
      end
      return v;
   endfunction

   // Scoreboard, hold and backpressure checks, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         pos_m      = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_coeff", out_coeff, hold_coeff);
            chk("hold_idx", out_idx, hold_idx);
            chk("hold_row", out_row, hold_row);
         end
         if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_beat", out_valid, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("coeff", out_coeff, e.coeff);
               chk("idx", out_idx, e.idx);
               chk("row", out_row, e.row);
               chk("col", out_col, e.col);
               chk("last", out_last, e.last);
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(model(in_coeff, pos_m));
            pos_m = (pos_m + 1) % (K*K);
         end
         stall_prev = out_valid && !out_ready;
         hold_coeff = out_coeff;
         hold_idx   = out_idx;
         hold_row   = out_row;
      end
   end

   task automatic send(input logic [43:0] v);
      in_valid = 1'b1;
      in_coeff = v;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (!in_ready) chk("send_timeout", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int t = 0; t < 300; t++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain", sb_q.size(), 0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_coeff  = 44'd0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_coeff", out_coeff, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_col", out_col, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Single beat, four-cycle latency
      send(pack4({1'b0, 10'd232}, {1'b0, 10'd279}, {1'b1, 10'd254}, 11'd0));
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("lat_early", out_valid, 0);
      @(negedge clk);
      chk("lat_valid", out_valid, 1);
`ifndef SORT_SIGNED_EN
      chk("t1_coeff", out_coeff, pack4({1'b0, 10'd279}, {1'b1, 10'd254}, {1'b0, 10'd232}, 11'd0));
      chk("t1_idx", out_idx, {2'd3, 2'd0, 2'd2, 2'd1});
`endif
      drain();

      // 26 back-to-back beats; beat 13 is the all-equal centre tap
      do_reset();
      for (int b = 0; b < 26; b++) begin
         if (b == 12) send(pack4({1'b0, 10'd512}, {1'b0, 10'd512}, {1'b0, 10'd512}, {1'b0, 10'd512}));
         else         send(rnd_beat());
      end
      drain();

      // Six-cycle stall with continuous input
      out_ready = 1'b0;
      fork
         begin
            repeat (6) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
         begin
            repeat (10) send(rnd_beat());
            in_valid = 1'b0;
         end
      join
      drain();

      // Random backpressure with bubbles
      fork
         begin
            for (int t = 0; t < 60; t++) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
         begin
            for (int b = 0; b < 30; b++) begin
               send(rnd_beat());
               if ((b % 7) == 3) begin
                  in_valid = 1'b0;
                  @(posedge clk);
                  #1;
               end
            end
            in_valid = 1'b0;
         end
      join
      drain();

`ifdef SORT_SIGNED_EN
      // Signed ranking with -0/+0 tie
      do_reset();
      send(pack4({1'b1, 10'd7}, {1'b0, 10'd5}, {1'b1, 10'd0}, {1'b0, 10'd0}));
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("t5_coeff", out_coeff, pack4({1'b0, 10'd5}, {1'b1, 10'd0}, {1'b0, 10'd0}, {1'b1, 10'd7}));
      chk("t5_idx", out_idx, {2'd0, 2'd3, 2'd2, 2'd1});
      drain();
`endif

      // Reset with three beats in flight
      send(rnd_beat());
      send(rnd_beat());
      send(rnd_beat());
      do_reset();
      @(negedge clk);
      chk("rst_flush_valid", out_valid, 0);
      @(posedge clk);
      #1;
      send(rnd_beat());
      in_valid = 1'b0;
      lat = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         lat = t;
         if (out_valid) break;
      end
      chk("rst_latency", lat, 3);
      chk("rst_row", out_row, 0);
      chk("rst_col", out_col, 0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
